// File: rtl/display_pkg.sv
// Shared types and constants for the display-side frame-buffer scan-out.
// Holds the scan state enum, the timing config record and its legality check.
package display_pkg;

   localparam int ADDR_W = 16;
   localparam int PIX_W  = 8;
   localparam int CFG_W  = 10;

   typedef enum logic [1:0] {
      SCAN_IDLE,
      SCAN_ACTIVE,
      SCAN_HBLANK,
      SCAN_VBLANK
   } scan_state_t;

   typedef struct packed {
      logic [CFG_W-1:0] hb;
      logic [CFG_W-1:0] vb;
      logic [CFG_W-1:0] aip;
      logic [CFG_W-1:0] ail;
   } cfg_t;

   // A frame must have at least one pixel and must fit in the addressable memory.
   function automatic logic cfg_legal(input cfg_t c, input int addr_w);
      logic [2*CFG_W-1:0] prod;
      prod = {{CFG_W{1'b0}}, c.aip} * {{CFG_W{1'b0}}, c.ail};
      return (c.aip != '0) && (c.ail != '0) && (64'(prod) <= (64'd1 << addr_w));
   endfunction

endpackage

// File: rtl/display_scan_out_scan_timing_gen.sv
// Raster timing generator: walks active lines, horizontal and vertical blanking
// and drives the frame memory read address with a running (multiply-free) counter.
module scan_timing_gen
   import display_pkg::*;
#(
   parameter int ADDR_W = display_pkg::ADDR_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  cfg_t              cfg,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic              h_blank,
   output logic              v_blank,
   output logic              frame_end,
   output logic              idle
);

   scan_state_t       state, state_n;
   logic [CFG_W-1:0]  col, col_n;
   logic [CFG_W-1:0]  line, line_n;
   logic [CFG_W-1:0]  blk, blk_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic              vb_hb, vb_hb_n;
   logic              line_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SCAN_IDLE;
         col   <= '0;
         line  <= '0;
         blk   <= '0;
         addr  <= '0;
         vb_hb <= 1'b0;
      end else begin
         state <= state_n;
         col   <= col_n;
         line  <= line_n;
         blk   <= blk_n;
         addr  <= addr_n;
         vb_hb <= vb_hb_n;
      end
   end

   // A vertical blank line is an active-length stretch (col) followed by an
   // hb-length stretch (blk, vb_hb=1), so every counter stays CFG_W bits wide.
   always_comb begin
      state_n   = state;
      col_n     = col;
      line_n    = line;
      blk_n     = blk;
      addr_n    = addr;
      vb_hb_n   = vb_hb;
      frame_end = 1'b0;
      line_end  = 1'b0;
      case (state)
         SCAN_IDLE: begin
            if (go) begin
               state_n = SCAN_ACTIVE;
               col_n   = '0;
               line_n  = '0;
               addr_n  = '0;
            end
         end
         SCAN_ACTIVE: begin
            addr_n = addr + 1'b1;
            if (col == cfg.aip - 1'b1) begin
               col_n = '0;
               if (cfg.hb != '0) begin
                  state_n = SCAN_HBLANK;
                  blk_n   = '0;
               end else if (line != cfg.ail - 1'b1) begin
                  line_n = line + 1'b1;
               end else if (cfg.vb != '0) begin
                  state_n = SCAN_VBLANK;
                  line_n  = '0;
                  vb_hb_n = 1'b0;
               end else begin
                  frame_end = 1'b1;
               end
            end else begin
               col_n = col + 1'b1;
            end
         end
         SCAN_HBLANK: begin
            if (blk == cfg.hb - 1'b1) begin
               if (line != cfg.ail - 1'b1) begin
                  state_n = SCAN_ACTIVE;
                  line_n  = line + 1'b1;
               end else if (cfg.vb != '0) begin
                  state_n = SCAN_VBLANK;
                  line_n  = '0;
                  col_n   = '0;
                  vb_hb_n = 1'b0;
               end else begin
                  frame_end = 1'b1;
               end
            end else begin
               blk_n = blk + 1'b1;
            end
         end
         SCAN_VBLANK: begin
            if (!vb_hb) begin
               if (col == cfg.aip - 1'b1) begin
                  col_n = '0;
                  if (cfg.hb != '0) begin
                     vb_hb_n = 1'b1;
                     blk_n   = '0;
                  end else begin
                     line_end = 1'b1;
                  end
               end else begin
                  col_n = col + 1'b1;
               end
            end else if (blk == cfg.hb - 1'b1) begin
               vb_hb_n  = 1'b0;
               line_end = 1'b1;
            end else begin
               blk_n = blk + 1'b1;
            end
            if (line_end) begin
               if (line == cfg.vb - 1'b1) frame_end = 1'b1;
               else                       line_n    = line + 1'b1;
            end
         end
         default: state_n = SCAN_IDLE;
      endcase
      // The last cycle of a frame chains straight into the next one, or parks in IDLE.
      if (frame_end) begin
         if (go) begin
            state_n = SCAN_ACTIVE;
            col_n   = '0;
            line_n  = '0;
            blk_n   = '0;
            addr_n  = '0;
            vb_hb_n = 1'b0;
         end else begin
            state_n = SCAN_IDLE;
         end
      end
   end

   always_comb begin
      idle    = (state == SCAN_IDLE);
      rd_en   = (state == SCAN_ACTIVE);
      rd_addr = (state == SCAN_ACTIVE) ? addr : '0;
      v_blank = (state == SCAN_VBLANK);
      h_blank = (state == SCAN_HBLANK) || ((state == SCAN_VBLANK) && vb_hb);
   end

endmodule

// File: rtl/display_scan_out.sv
// Frame-buffer scan-out: config shadowing and legality check around the timing
// generator, plus the one-cycle stage that aligns flags with returning read data.
module display_scan_out
   import display_pkg::*;
#(
   parameter int ADDR_W = display_pkg::ADDR_W,
   parameter int PIX_W  = display_pkg::PIX_W,
   parameter int CFG_W  = display_pkg::CFG_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              CSDisplay,
   input  logic [CFG_W-1:0]  HBOut_PD,
   input  logic [CFG_W-1:0]  VBOut_PD,
   input  logic [CFG_W-1:0]  AIPOut_PD,
   input  logic [CFG_W-1:0]  AILOut_PD,
   output logic [ADDR_W-1:0] FrameRAddr,
   output logic              FrameREn,
   input  logic [PIX_W-1:0]  FrameRData,
   output logic [PIX_W-1:0]  PixelOut,
   output logic              PixelValid,
   output logic              HBlank,
   output logic              VBlank,
   output logic              FrameDone,
   output logic              ConfigErr
);

   cfg_t              live_cfg;
   cfg_t              shadow_cfg;
   logic              live_ok;
   logic              go;
   logic              latch_pt;
   logic              gen_idle;
   logic              gen_frame_end;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic              h_blank;
   logic              v_blank;
   logic              pix_valid_q;
   logic              h_blank_q;
   logic              v_blank_q;
   logic              frame_done_q;
   logic              cfg_err_q;

   assign live_cfg = '{hb: HBOut_PD, vb: VBOut_PD, aip: AIPOut_PD, ail: AILOut_PD};
   assign live_ok  = cfg_legal(live_cfg, ADDR_W);
   assign go       = CSDisplay && live_ok;
   assign latch_pt = gen_idle || gen_frame_end;

   scan_timing_gen #(.ADDR_W(ADDR_W)) u_timing (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .cfg       (shadow_cfg),
      .rd_addr   (rd_addr),
      .rd_en     (rd_en),
      .h_blank   (h_blank),
      .v_blank   (v_blank),
      .frame_end (gen_frame_end),
      .idle      (gen_idle)
   );

   // Config is only sampled in IDLE or on a frame's last cycle, so mid-frame edits wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_cfg <= '0;
         cfg_err_q  <= 1'b0;
      end else if (latch_pt && CSDisplay) begin
         shadow_cfg <= live_cfg;
         if (!live_ok)      cfg_err_q <= 1'b1;
         else if (gen_idle) cfg_err_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_valid_q  <= 1'b0;
         h_blank_q    <= 1'b0;
         v_blank_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         pix_valid_q  <= rd_en;
         h_blank_q    <= h_blank;
         v_blank_q    <= v_blank;
         frame_done_q <= gen_frame_end;
      end
   end

   // Read data arrives one cycle after the enable, exactly when the valid stage is high.
   assign PixelOut   = pix_valid_q ? FrameRData : '0;
   assign PixelValid = pix_valid_q;
   assign HBlank     = h_blank_q;
   assign VBlank     = v_blank_q;
   assign FrameDone  = frame_done_q;
   assign FrameREn   = rd_en;
   assign FrameRAddr = rd_addr;
   assign ConfigErr  = cfg_err_q;

endmodule

// File: tb/tb_display_scan_out.sv
// Directed scoreboard bench for display_scan_out: expected per-cycle output
// records are queued from a raster model and popped against the DUT each cycle.
module tb_display_scan_out;

   logic        clk = 1'b0;
   logic        reset;
   logic        CSDisplay;
   logic [9:0]  HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD;
   logic [15:0] FrameRAddr;
   logic        FrameREn;
   logic [7:0]  FrameRData;
   logic [7:0]  PixelOut;
   logic        PixelValid, HBlank, VBlank, FrameDone, ConfigErr;

   int checks = 0;
   int errors = 0;
   int valid_seen = 0;
   logic [11:0] exp_q[$];

   display_scan_out dut (
      .clk        (clk),
      .reset      (reset),
      .CSDisplay  (CSDisplay),
      .HBOut_PD   (HBOut_PD),
      .VBOut_PD   (VBOut_PD),
      .AIPOut_PD  (AIPOut_PD),
      .AILOut_PD  (AILOut_PD),
      .FrameRAddr (FrameRAddr),
      .FrameREn   (FrameREn),
      .FrameRData (FrameRData),
      .PixelOut   (PixelOut),
      .PixelValid (PixelValid),
      .HBlank     (HBlank),
      .VBlank     (VBlank),
      .FrameDone  (FrameDone),
      .ConfigErr  (ConfigErr)
   );

   always #5 clk = ~clk;

   // Memory preloaded with addr[7:0]; junk when not enabled so ungated data is visible.
   always @(posedge clk) begin
      FrameRData <= FrameREn ? FrameRAddr[7:0] : 8'hEE;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic cs, input int hb, input int vb, input int aip, input int ail);
      CSDisplay = cs;
      HBOut_PD  = 10'(hb);
      VBOut_PD  = 10'(vb);
      AIPOut_PD = 10'(aip);
      AILOut_PD = 10'(ail);
   endtask

   // Record layout: {valid, pixel[7:0], hblank, vblank, framedone}
   task automatic pushFrame(input int hb, input int vb, input int aip, input int ail);
      int total_lines, line_len;
      logic act;
      logic [7:0] pix;
      total_lines = ail + vb;
      line_len    = aip + hb;
      for (int y = 0; y < total_lines; y++) begin
         for (int x = 0; x < line_len; x++) begin
            act = (y < ail) && (x < aip);
            pix = act ? 8'((y * aip + x) % 256) : 8'h00;
            exp_q.push_back({act, pix, (x >= aip), (y >= ail),
                             (y == total_lines - 1) && (x == line_len - 1)});
         end
      end
   endtask

   task automatic pushIdle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(12'h000);
   endtask

   task automatic checkOutput(input int n, input string tag);
      logic [11:0] obs, expv;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs = {PixelValid, PixelOut, HBlank, VBlank, FrameDone};
         if (PixelValid) valid_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s queue-empty step %0d observed %h expected none", tag, i, obs);
         end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
               errors++;
               $error("[TB] FAIL %s step %0d observed %h expected %h", tag, i, obs, expv);
            end
         end
      end
   endtask

   task automatic expectStart(input string tag);
      @(negedge clk);
      checks++;
      assert ({FrameREn, FrameRAddr} === {1'b1, 16'h0000}) else begin
         errors++;
         $error("[TB] FAIL %s start-read observed %b/%h expected 1/0000", tag, FrameREn, FrameRAddr);
      end
   endtask

   task automatic checkBit(input logic obs, input logic expv, input string tag);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed %b expected %b", tag, obs, expv);
      end
   endtask

   initial begin
      int vs0;
      reset = 1'b1;
      FrameRData = 8'h00;
      applyStimulus(1'b0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      assert ({PixelValid, PixelOut, HBlank, VBlank, FrameDone, FrameREn, FrameRAddr, ConfigErr} === 30'h0)
      else begin
         errors++;
         $error("[TB] FAIL reset-state observed %b%h%b%b%b%b%h%b expected all zero",
                PixelValid, PixelOut, HBlank, VBlank, FrameDone, FrameREn, FrameRAddr, ConfigErr);
      end
      reset = 1'b0;
      @(negedge clk);

      // Small frame 4/2 active, HB=2, VB=1, single frame then idle
      applyStimulus(1'b1, 2, 1, 4, 2);
      pushFrame(2, 1, 4, 2);
      expectStart("small");
      checkOutput(2, "small");
      CSDisplay = 1'b0;
      pushIdle(2);
      checkOutput(18, "small");
      checkBit(ConfigErr, 1'b0, "small-cfgerr");

      // Zero blanking, three back-to-back 3x3 frames
      applyStimulus(1'b1, 0, 0, 3, 3);
      pushFrame(0, 0, 3, 3);
      pushFrame(0, 0, 3, 3);
      pushFrame(0, 0, 3, 3);
      expectStart("zeroblank");
      checkOutput(22, "zeroblank");
      CSDisplay = 1'b0;
      pushIdle(3);
      checkOutput(8, "zeroblank");

      // Continuous run, geometry edited mid-frame takes effect next frame
      applyStimulus(1'b1, 2, 1, 4, 2);
      pushFrame(2, 1, 4, 2);
      expectStart("cfgchange");
      checkOutput(6, "cfgchange-a");
      applyStimulus(1'b1, 1, 0, 3, 2);
      pushFrame(1, 0, 3, 2);
      checkOutput(12, "cfgchange-a");
      checkOutput(4, "cfgchange-b");
      CSDisplay = 1'b0;
      pushIdle(3);
      checkOutput(7, "cfgchange-b");

      // Illegal configs: zero width, then oversize product; flag is sticky
      applyStimulus(1'b1, 2, 1, 0, 2);
      @(negedge clk);
      checkBit(ConfigErr, 1'b1, "illegal-aip0-err");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkBit(FrameREn, 1'b0, "illegal-aip0-ren");
      end
      applyStimulus(1'b1, 0, 0, 257, 256);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkBit(FrameREn, 1'b0, "illegal-size-ren");
      end
      CSDisplay = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkBit(ConfigErr, 1'b1, "illegal-sticky");
      applyStimulus(1'b1, 2, 1, 4, 2);
      pushFrame(2, 1, 4, 2);
      expectStart("recover");
      checkBit(ConfigErr, 1'b0, "recover-cfgerr");
      checkOutput(2, "recover");
      CSDisplay = 1'b0;
      pushIdle(2);
      checkOutput(18, "recover");

      // Async reset while pixel 5 is on the output
      applyStimulus(1'b1, 1, 1, 8, 2);
      pushFrame(1, 1, 8, 2);
      expectStart("reset");
      checkOutput(5, "reset");
      @(posedge clk);
      #1;
      checkBit(PixelValid, 1'b1, "reset-pre-valid");
      reset = 1'b1;
      #1;
      checks++;
      assert ({PixelValid, PixelOut, HBlank, VBlank, FrameDone, FrameREn, FrameRAddr} === 29'h0)
      else begin
         errors++;
         $error("[TB] FAIL midreset observed %b%h%b%b%b%b%h expected all zero",
                PixelValid, PixelOut, HBlank, VBlank, FrameDone, FrameREn, FrameRAddr);
      end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      expectStart("after-reset");
      pushFrame(1, 1, 8, 2);
      checkOutput(3, "after-reset");
      CSDisplay = 1'b0;
      pushIdle(2);
      checkOutput(26, "after-reset");

      // Full-size 100x100 frame with scan enable dropped halfway
      applyStimulus(1'b1, 10, 10, 100, 100);
      pushFrame(10, 10, 100, 100);
      vs0 = valid_seen;
      expectStart("full");
      checkOutput(5000, "full");
      CSDisplay = 1'b0;
      pushIdle(3);
      checkOutput(7103, "full");
      checks++;
      assert ((valid_seen - vs0) === 100 * 100) else begin
         errors++;
         $error("[TB] FAIL full-valid-count observed %0d expected %0d", valid_seen - vs0, 100 * 100);
      end
      checkBit(FrameREn, 1'b0, "full-idle-ren");

      checks++;
      assert (exp_q.size() === 0) else begin
         errors++;
         $error("[TB] FAIL leftover-queue observed %0d expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
